// File: rtl/mult_pkg.sv
// Widths shared by the 8x8 multiplier stage and the product accumulator.
// Also holds the state type of the accumulator's result register.
package mult_pkg;

  localparam int PRODUCT_W     = 16;
  localparam int ACC_W_DEFAULT = 24;
  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/product_accumulator_if.sv
// Product-beat input stream and frame-result output stream of the accumulator.
// The master side is the multiplier/consumer pair; the accumulator is the slave.
interface product_accumulator_if
  import mult_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic                 in_valid;
  logic                 in_ready;
  logic [PRODUCT_W-1:0] in_product;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     out_sum;
  logic [CNT_W-1:0]     out_count;
  logic                 out_overflow;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );

endinterface

// File: rtl/product_accumulator_sat_add.sv
// Unsigned saturating adder: clamps to all-ones and flags sat on carry out.
module sat_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat
);

  logic [W:0] full_s;

  // Widen by one bit so the carry out marks the saturation case.
  always_comb begin
    full_s = {1'b0, a} + {1'b0, b};
    if (full_s[W]) begin
      sum = {W{1'b1}};
      sat = 1'b1;
    end else begin
      sum = full_s[W-1:0];
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums a stream of 16-bit products into per-frame results delimited by in_last,
// holding each finished frame in a single-entry valid/ready output register.
module product_accumulator
  import mult_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input logic                  clk,
  input logic                  reset,
  product_accumulator_if.slave bus
);

  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ovf_r;
  out_state_t       state_r;
  logic [ACC_W-1:0] sum_r;
  logic [CNT_W-1:0] count_r;
  logic             overflow_r;

  logic [ACC_W-1:0] product_ext_s;
  logic [ACC_W-1:0] acc_next_s;
  logic             acc_sat_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             cnt_sat_s;
  logic             ovf_next_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             accept_last_s;

  assign product_ext_s = ACC_W'(bus.in_product);

  sat_add #(.W(ACC_W)) u_sum_add (
    .a   (acc_r),
    .b   (product_ext_s),
    .sum (acc_next_s),
    .sat (acc_sat_s)
  );

  sat_add #(.W(CNT_W)) u_cnt_add (
    .a   (cnt_r),
    .b   (CNT_W'(1'b1)),
    .sum (cnt_next_s),
    .sat (cnt_sat_s)
  );

  // Any beat, not only the last, waits while a finished result is blocked.
  assign in_ready_s    = (state_r == OUT_EMPTY) || bus.out_ready;
  assign accept_s      = bus.in_valid && in_ready_s;
  assign accept_last_s = accept_s && bus.in_last;
  assign ovf_next_s    = ovf_r || acc_sat_s || cnt_sat_s;

  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = (state_r == OUT_FULL);
  assign bus.out_sum      = sum_r;
  assign bus.out_count    = count_r;
  assign bus.out_overflow = overflow_r;

  // Running frame totals; a last beat restarts them so the next frame begins clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r <= {ACC_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (accept_last_s) begin
      acc_r <= {ACC_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (accept_s) begin
      acc_r <= acc_next_s;
      cnt_r <= cnt_next_s;
      ovf_r <= ovf_next_s;
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
      ovf_r <= ovf_r;
    end
  end

  // Result register: a new frame result may replace one leaving in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= OUT_EMPTY;
      sum_r      <= {ACC_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (accept_last_s) begin
        sum_r      <= acc_next_s;
        count_r    <= cnt_next_s;
        overflow_r <= ovf_next_s;
      end else begin
        sum_r      <= sum_r;
        count_r    <= count_r;
        overflow_r <= overflow_r;
      end
      case (state_r)
        OUT_EMPTY: begin
          if (accept_last_s) begin
            state_r <= OUT_FULL;
          end else begin
            state_r <= OUT_EMPTY;
          end
        end
        OUT_FULL: begin
          if (accept_last_s) begin
            state_r <= OUT_FULL;
          end else if (bus.out_ready) begin
            state_r <= OUT_EMPTY;
          end else begin
            state_r <= OUT_FULL;
          end
        end
        default: state_r <= OUT_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Drives three accumulators (24/8, 17/8, 24/2 bits) with identical streams and
// checks them against a frame-level arithmetic model plus fixed vector tables.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_product = 16'h0000;

  always #5 clk = ~clk;

  product_accumulator_if #(.ACC_W(24), .CNT_W(8)) if_a ();
  product_accumulator_if #(.ACC_W(17), .CNT_W(8)) if_b ();
  product_accumulator_if #(.ACC_W(24), .CNT_W(2)) if_c ();

  assign if_a.in_valid = in_valid;  assign if_a.in_product = in_product;
  assign if_a.in_last  = in_last;   assign if_a.out_ready  = out_ready;
  assign if_b.in_valid = in_valid;  assign if_b.in_product = in_product;
  assign if_b.in_last  = in_last;   assign if_b.out_ready  = out_ready;
  assign if_c.in_valid = in_valid;  assign if_c.in_product = in_product;
  assign if_c.in_last  = in_last;   assign if_c.out_ready  = out_ready;

  product_accumulator #(.ACC_W(24), .CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  product_accumulator #(.ACC_W(17), .CNT_W(8)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
  product_accumulator #(.ACC_W(24), .CNT_W(2)) dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

  logic [63:0] sum_w [3];
  logic [63:0] cnt_w [3];
  logic        ovf_w [3];
  logic        vld_w [3];
  logic        rdy_w [3];

  assign sum_w[0] = 64'(if_a.out_sum);   assign cnt_w[0] = 64'(if_a.out_count);
  assign sum_w[1] = 64'(if_b.out_sum);   assign cnt_w[1] = 64'(if_b.out_count);
  assign sum_w[2] = 64'(if_c.out_sum);   assign cnt_w[2] = 64'(if_c.out_count);
  assign ovf_w[0] = if_a.out_overflow;   assign vld_w[0] = if_a.out_valid;   assign rdy_w[0] = if_a.in_ready;
  assign ovf_w[1] = if_b.out_overflow;   assign vld_w[1] = if_b.out_valid;   assign rdy_w[1] = if_b.in_ready;
  assign ovf_w[2] = if_c.out_overflow;   assign vld_w[2] = if_c.out_valid;   assign rdy_w[2] = if_c.in_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: beats of the open frame and the result each DUT should hold.
  longint      frame_q[$];
  logic        m_full = 1'b0;
  logic [63:0] h_sum [3];
  logic [63:0] h_cnt [3];
  logic        h_ovf [3];

  typedef struct {
    logic [15:0] p;
    logic        l;
    logic [23:0] s0, s1, s2;
    logic [7:0]  c0, c1, c2;
    logic [2:0]  o;
  } vec_t;
  vec_t tbl[$];

  function automatic int aw_of(input int k);
    return (k == 1) ? 17 : 24;
  endfunction

  function automatic int cw_of(input int k);
    return (k == 2) ? 2 : 8;
  endfunction

  function automatic void frame_result(input int k, output logic [63:0] s,
                                       output logic [63:0] c, output logic o);
    longint tot = 0;
    longint n   = frame_q.size();
    longint smax = (longint'(1) << aw_of(k)) - 1;
    longint cmax = (longint'(1) << cw_of(k)) - 1;
    foreach (frame_q[i]) tot += frame_q[i];
    s = 64'((tot > smax) ? smax : tot);
    c = 64'((n > cmax) ? cmax : n);
    o = (tot > smax) || (n > cmax);
  endfunction

  task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
    end
  endtask

  task automatic check_held();
    for (int k = 0; k < 3; k++) begin
      check("out_valid", k, 64'(vld_w[k]), 64'(m_full));
      if (m_full) begin
        check("out_sum", k, sum_w[k], h_sum[k]);
        check("out_count", k, cnt_w[k], h_cnt[k]);
        check("out_overflow", k, 64'(ovf_w[k]), 64'(h_ovf[k]));
      end
    end
  endtask

  // One clock: drive at the falling edge, update the model, check after the next falling edge.
  task automatic cycle(input logic v, input logic [15:0] p, input logic l, input logic r);
    logic rdy_exp;
    logic acc;
    in_valid = v; in_product = p; in_last = l; out_ready = r;
    #1;
    rdy_exp = !m_full || r;
    for (int k = 0; k < 3; k++) check("in_ready", k, 64'(rdy_w[k]), 64'(rdy_exp));
    acc = v && rdy_exp;
    if (acc) frame_q.push_back(longint'(p));
    if (acc && l) begin
      for (int k = 0; k < 3; k++) frame_result(k, h_sum[k], h_cnt[k], h_ovf[k]);
      frame_q.delete();
      m_full = 1'b1;
    end else if (m_full && r) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_held();
  endtask

  task automatic check_reset_vals(input string name);
    for (int k = 0; k < 3; k++) begin
      check({name, "_valid"}, k, 64'(vld_w[k]), 64'd0);
      check({name, "_sum"}, k, sum_w[k], 64'd0);
      check({name, "_count"}, k, cnt_w[k], 64'd0);
      check({name, "_ovf"}, k, 64'(ovf_w[k]), 64'd0);
      check({name, "_in_ready"}, k, 64'(rdy_w[k]), 64'd1);
    end
  endtask

  // Called at a falling edge; holds reset across one rising edge.
  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    #1;
    check_reset_vals("rst_async");
    frame_q.delete();
    m_full = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_hold");
    reset = 1'b1;
  endtask

  initial begin
    tbl.push_back('{16'h0006, 1'b0, 24'h0, 24'h0, 24'h0, 8'd0, 8'd0, 8'd0, 3'b000});
    tbl.push_back('{16'h000C, 1'b0, 24'h0, 24'h0, 24'h0, 8'd0, 8'd0, 8'd0, 3'b000});
    tbl.push_back('{16'h0012, 1'b1, 24'h24, 24'h24, 24'h24, 8'd3, 8'd3, 8'd3, 3'b000});
    tbl.push_back('{16'hFFFF, 1'b0, 24'h0, 24'h0, 24'h0, 8'd0, 8'd0, 8'd0, 3'b000});
    tbl.push_back('{16'hFFFF, 1'b0, 24'h0, 24'h0, 24'h0, 8'd0, 8'd0, 8'd0, 3'b000});
    tbl.push_back('{16'h0002, 1'b1, 24'h20000, 24'h1FFFF, 24'h20000, 8'd3, 8'd3, 8'd3, 3'b010});
    tbl.push_back('{16'h0001, 1'b1, 24'h1, 24'h1, 24'h1, 8'd1, 8'd1, 8'd1, 3'b000});
    tbl.push_back('{16'h0002, 1'b1, 24'h2, 24'h2, 24'h2, 8'd1, 8'd1, 8'd1, 3'b000});
    tbl.push_back('{16'h0003, 1'b1, 24'h3, 24'h3, 24'h3, 8'd1, 8'd1, 8'd1, 3'b000});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{16'h0001, 1'b0, 24'h0, 24'h0, 24'h0, 8'd0, 8'd0, 8'd0, 3'b000});
    tbl.push_back('{16'h0001, 1'b1, 24'h5, 24'h5, 24'h5, 8'd5, 8'd5, 8'd3, 3'b100});
    tbl.push_back('{16'h0000, 1'b1, 24'h0, 24'h0, 24'h0, 8'd1, 8'd1, 8'd1, 3'b000});
    tbl.push_back('{16'h0000, 1'b0, 24'h0, 24'h0, 24'h0, 8'd0, 8'd0, 8'd0, 3'b000});
    tbl.push_back('{16'h0007, 1'b1, 24'h7, 24'h7, 24'h7, 8'd2, 8'd2, 8'd2, 3'b000});

    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      cycle(1'b1, tbl[i].p, tbl[i].l, 1'b1);
      if (tbl[i].l) begin
        check("tbl_sum", 0, sum_w[0], 64'(tbl[i].s0));
        check("tbl_sum", 1, sum_w[1], 64'(tbl[i].s1));
        check("tbl_sum", 2, sum_w[2], 64'(tbl[i].s2));
        check("tbl_count", 0, cnt_w[0], 64'(tbl[i].c0));
        check("tbl_count", 1, cnt_w[1], 64'(tbl[i].c1));
        check("tbl_count", 2, cnt_w[2], 64'(tbl[i].c2));
        for (int k = 0; k < 3; k++) check("tbl_ovf", k, 64'(ovf_w[k]), 64'(tbl[i].o[k]));
      end
    end
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);

    // Blocked result: offered beat must wait, then enter as the result leaves.
    cycle(1'b1, 16'h0010, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 16'h0033, 1'b1, 1'b0);
      check("stall_sum", 0, sum_w[0], 64'h10);
    end
    cycle(1'b1, 16'h0033, 1'b1, 1'b1);
    check("after_stall_sum", 0, sum_w[0], 64'h33);
    check("after_stall_count", 0, cnt_w[0], 64'd1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);

    // Reset in the middle of a frame, with a result also held.
    cycle(1'b1, 16'h0009, 1'b1, 1'b0);
    cycle(1'b1, 16'h0100, 1'b0, 1'b1);
    cycle(1'b1, 16'h0200, 1'b0, 1'b1);
    do_reset();
    cycle(1'b1, 16'h0005, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check("rst_frame_sum", k, sum_w[k], 64'd5);
      check("rst_frame_count", k, cnt_w[k], 64'd1);
    end
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);

    for (int i = 0; i < 800; i++) begin
      logic        v, l, r;
      logic [15:0] p;
      v = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
      l = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 2) != 0);
      cycle(v, p, l, r);
    end
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Accumulates a stream of 16-bit products from the 8×8 multiplier stage into per-frame sums. Frames are delimited by a last flag. Each completed frame is presented on a registered valid/ready output together with its beat count and an overflow flag. The block sits directly downstream of the multiplier and turns single products into dot-product style results for the next consumer.

## Interface
- ACC_W, 24, accumulator and output sum width; must be ≥ 16
- CNT_W, 8, beat counter width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- in_valid  input  1  product beat present
- in_ready  output  1  block can accept a beat this cycle
- in_product  input  16  unsigned product
- in_last  input  1  beat is final of its frame
- out_valid  output  1  frame result held
- out_ready  input  1  downstream accepts result
- out_sum  output  ACC_W  frame sum, saturating
- out_count  output  CNT_W  beats in frame, saturating
- out_overflow  output  1  sum or count saturated during frame

## Operation
- Beat accepted when in_valid && in_ready; in_product zero-extended to ACC_W and added to running acc.
- Saturating add: if acc + product ≥ 2^ACC_W, acc := 2^ACC_W−1 and frame ovf := 1. Count saturates at 2^CNT_W−1 and also sets ovf.
- Two states:
  - ACCUM: running frame; acc/cnt/ovf update per accepted beat.
  - The output register is either empty or FULL; it is tracked by out_valid.
- Accepted beat with in_last: the final (acc+product, cnt+1, ovf) values load the output register; out_valid := 1; acc, cnt and ovf clear to 0 in the same edge, so the next frame starts clean.
- in_ready = !out_valid || out_ready. Non-last beats are stalled too when the output is blocked (simple rule, no exceptions).
- Output handshake: out_valid && out_ready clears out_valid, unless a last beat is accepted the same cycle, in which case the new result loads and out_valid stays 1.
- Single-beat frame (first beat has in_last) → sum = product, count = 1.
- Zero product beats count normally.

## Timing
- Reset (reset = 0, async): acc = 0, cnt = 0, ovf = 0, out_valid = 0, out_sum = 0, out_count = 0, out_overflow = 0. in_ready = 1 once reset deasserts.
- Reset mid-frame discards the partial frame and any held result; no output is produced for it.
- Latency: out_valid rises on the clock edge that accepts the last beat, so the result is visible the next cycle.
- Throughput: one beat per cycle while out_ready = 1. A back-to-back last every cycle sustains one result per cycle.
- out_sum, out_count and out_overflow stay stable while out_valid && !out_ready.
- in_ready has a combinational path from out_ready only; there are no other combinational input→output paths.

## Structure
- Shared package mult_pkg holds PRODUCT_W = 16, ACC_W_DEFAULT = 24 and CNT_W_DEFAULT = 8. The multiplier and accumulator share it.
- One sub-module, sat_add: a parameterised unsigned saturating adder with outputs sum and sat. It is used for the sum path and, with a +1 operand, for the count path.
- The top level holds acc/cnt/ovf, the output register and the handshake logic.

## Test plan
- Frame 0x0006, 0x000C, 0x0012(last), out_ready = 1 → one result: out_sum = 0x000024, out_count = 3, out_overflow = 0.
- ACC_W = 17: frame 0xFFFF, 0xFFFF, 0x0002(last) → out_sum = 0x1FFFF, out_count = 3, out_overflow = 1. The next frame 0x0001(last) gives out_sum = 1, out_overflow = 0.
- Frame 0x0010(last) with out_ready = 0 for 5 cycles → out_valid held and outputs stable, in_ready = 0 throughout. A beat offered meanwhile is not consumed; it is accepted the cycle out_ready = 1.
- Continuous single-beat frames 1, 2, 3, out_ready = 1 → out_valid stays high for 3 consecutive cycles with sums 1, 2, 3, each with count 1.
- Beats 0x0100, 0x0200, then reset pulled low for one cycle, then 0x0005(last) → the only result is out_sum = 5, out_count = 1. All outputs read 0 during reset.
- CNT_W = 2: five beats of 0x0001, last on the fifth → out_count = 3, out_sum = 5, out_overflow = 1.
